pipe_approx_adder: RTL and testbench

- Parametrised, two-stage pipelined N-bit adder with run-time selectable exact/approximate mode.
- Approximate mode replaces the low APPROX_BITS positions with OR-sum / AND-carry half-adder cells.
- Valid/ready handshake on both sides; data registers load only on accept, giving a clean clock-gating enable.
- Sits in the partial-product reduction / final-add path of the approximate multiplier.

---
 rtl/approx_add_pkg.sv | 26 ++
 rtl/approx_add_slice.sv | 43 ++++
 rtl/pipe_approx_adder.sv | 115 +++++++++++
 tb/tb_pipe_approx_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_pkg.sv
// approx_add_pkg: shared mode encodings, counter width and the reference approximate-sum function.
`default_nettype none
package approx_add_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;
  localparam int   ERR_CNT_W   = 16;

  // Arithmetic reference: OR-sum low bits, keep only the top approximated carry, exact above.
  function automatic logic [63:0] approx_sum_ref(input logic [63:0] a, input logic [63:0] b,
                                                 input logic mode, input int width,
                                                 input int approx_bits);
    logic [63:0] aa, bb, lo_mask, lo, upper;
    logic        c;
    aa = a & ((64'd1 << width) - 64'd1);
    bb = b & ((64'd1 << width) - 64'd1);
    if (mode == MODE_EXACT || approx_bits == 0) return aa + bb;
    lo_mask = (64'd1 << approx_bits) - 64'd1;
    lo      = (aa | bb) & lo_mask;
    c       = aa[approx_bits-1] & bb[approx_bits-1];
    upper   = (aa >> approx_bits) + (bb >> approx_bits) + {63'd0, c};
    return (upper << approx_bits) | lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/approx_add_slice.sv
// approx_add_slice: combinational W-bit adder whose low APPROX_BITS cells become OR-sum/AND-carry in approx mode.
`default_nettype none
module approx_add_slice
  import approx_add_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         mode,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] exact;
  assign exact = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  generate
    if (APPROX_BITS == 0) begin : g_exact_only
      logic unused_mode;
      assign unused_mode = mode;
      assign {cout, sum} = exact;
    end else begin : g_approx
      logic [W:0] approx;
      logic       c_keep;
      // cin is dropped in approx mode: the low half is always fed with zero.
      assign c_keep = a[APPROX_BITS-1] & b[APPROX_BITS-1];
      if (APPROX_BITS == W) begin : g_all_approx
        assign approx = {c_keep, a | b};
      end else begin : g_part_approx
        logic [W-APPROX_BITS:0] upper;
        assign upper = {1'b0, a[W-1:APPROX_BITS]} + {1'b0, b[W-1:APPROX_BITS]}
                     + {{(W-APPROX_BITS){1'b0}}, c_keep};
        assign approx = {upper, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]};
      end
      assign {cout, sum} = (mode == MODE_APPROX) ? approx : exact;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_approx_adder.sv
// pipe_approx_adder: two-stage valid/ready adder, low half approximable at run time.
// Optional APPROX_STATS_EN adds err_cnt, counting approx results that differ from exact.
`default_nettype none
module pipe_approx_adder
  import approx_add_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  output logic                 out_mode
`ifdef APPROX_STATS_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic            s1_valid, s2_valid, s2_free, accept, s1_adv;
  logic [LO_W-1:0] lo_sum, s1_lo;
  logic            c_lo, s1_clo, s1_mode;
  logic [HI_W-1:0] s1_a_hi, s1_b_hi, hi_sum;
  logic            hi_cout;

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign out_valid = s2_valid;

  approx_add_slice #(.W(LO_W), .APPROX_BITS(APPROX_BITS)) u_lo (
    .a(in_a[LO_W-1:0]), .b(in_b[LO_W-1:0]), .cin(1'b0), .mode(in_mode),
    .sum(lo_sum), .cout(c_lo)
  );

  approx_add_slice #(.W(HI_W), .APPROX_BITS(0)) u_hi (
    .a(s1_a_hi), .b(s1_b_hi), .cin(s1_clo), .mode(MODE_EXACT),
    .sum(hi_sum), .cout(hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv)         s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  // Data registers only load on accept/advance, so they double as clock-gate enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_lo    <= '0;
      s1_clo   <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_mode  <= MODE_EXACT;
      out_sum  <= '0;
      out_mode <= MODE_EXACT;
    end else begin
      if (accept) begin
        s1_lo   <= lo_sum;
        s1_clo  <= c_lo;
        s1_a_hi <= in_a[WIDTH-1:LO_W];
        s1_b_hi <= in_b[WIDTH-1:LO_W];
        s1_mode <= in_mode;
      end
      if (s1_adv) begin
        out_sum  <= {hi_cout, hi_sum, s1_lo};
        out_mode <= s1_mode;
      end
    end
  end

`ifdef APPROX_STATS_EN
  logic [LO_W-1:0] lo_exact;
  logic            c_lo_exact, s1_err, s2_err;

  approx_add_slice #(.W(LO_W), .APPROX_BITS(0)) u_lo_exact (
    .a(in_a[LO_W-1:0]), .b(in_b[LO_W-1:0]), .cin(1'b0), .mode(MODE_EXACT),
    .sum(lo_exact), .cout(c_lo_exact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err  <= 1'b0;
      s2_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) s1_err <= ({c_lo, lo_sum} != {c_lo_exact, lo_exact});
      if (s1_adv) s2_err <= s1_err;
      if (s2_valid && out_ready && (out_mode == MODE_APPROX) && s2_err && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  // Without stats the exact shadow adder and mismatch pipeline are not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_approx_adder.sv
// tb_pipe_approx_adder: scoreboard bench, random and directed traffic against an arithmetic reference.
`default_nettype none
module tb_pipe_approx_adder;
  import approx_add_pkg::*;

  localparam int WIDTH = 16;
  localparam int AB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_mode;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready, out_mode;
  logic [WIDTH:0]   out_sum;
`ifdef APPROX_STATS_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  int exp_err = 0;
`endif

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           mode;
    logic           err;
  } exp_t;

  exp_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_approx_adder #(.WIDTH(WIDTH), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_mode(out_mode)
`ifdef APPROX_STATS_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic m);
    logic [63:0] r, rx;
    exp_t e;
    r      = approx_sum_ref({48'd0, a}, {48'd0, b}, m, WIDTH, AB);
    rx     = approx_sum_ref({48'd0, a}, {48'd0, b}, MODE_EXACT, WIDTH, AB);
    e.sum  = r[WIDTH:0];
    e.mode = m;
    e.err  = (m == MODE_APPROX) && (r != rx);
    return e;
  endfunction

  // Monitor: every output transfer is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got sum 0x%0h, want no output", out_sum);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_mode", 32'(out_mode), 32'(e.mode));
`ifdef APPROX_STATS_EN
        if (e.err && exp_err < 65535) exp_err++;
`endif
      end
    end
  end

  // Presents one operand until accepted; entered and left at posedge+1.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m,
                       output int stalls);
    bit acc;
    stalls   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    forever begin
      acc = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(a, b, m));
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
      if (stalls >= 50) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want accept", stalls);
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic m, input logic [WIDTH:0] want);
    int st;
    issue(a, b, m, st);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_lat_valid"}, 32'(out_valid), 32'd1);
    check({name, "_sum"}, 32'(out_sum), 32'(want));
    @(negedge clk);
`ifdef APPROX_STATS_EN
    check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls_total, st, acc, seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    directed("exact_basic", 16'h00FF, 16'h0001, MODE_EXACT, 17'h00100);
    directed("approx_drop", 16'h000F, 16'h0001, MODE_APPROX, 17'h0000F);
    directed("approx_keep", 16'h0008, 16'h0008, MODE_APPROX, 17'h00018);
    directed("cross_half", 16'hFFFF, 16'h0001, MODE_EXACT, 17'h10000);
    directed("approx_top", 16'hFFFF, 16'hFFFF, MODE_APPROX, 17'h1FFFF);

    // Streaming: alternate modes, no bubbles allowed with out_ready high.
    stalls_total = 0;
    for (int i = 0; i < 100; i++) begin
      issue(16'($urandom), 16'($urandom), 1'(i % 2), st);
      stalls_total += st;
    end
    in_valid = 1'b0;
    check("stream_bubbles", 32'(stalls_total), 32'd0);
    repeat (4) @(negedge clk);
    check("stream_drained", 32'(sbq.size()), 32'd0);

    // Backpressure: only two slots exist, output must hold steady.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      in_mode  = 1'($urandom);
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(in_a, in_b, in_mode));
        acc++;
      end
      if (k >= 2 && sbq.size() > 0) check("bp_sum_hold", 32'(out_sum), 32'(sbq[0].sum));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_1", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drain_2", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drain_empty", 32'(out_valid), 32'd0);
    check("bp_queue_empty", 32'(sbq.size()), 32'd0);

    // Reset with two transactions in flight.
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), st);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
`ifdef APPROX_STATS_EN
    exp_err = 0;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef APPROX_STATS_EN
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_stale", 32'(seen), 32'd0);

    // Traffic after reset, including an immediate back-to-back burst.
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) issue(16'($urandom), 16'($urandom), 1'($urandom), st);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("final_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
